// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Serialises ecall / illegal-instruction / timer-interrupt / mret events into
//   multi-cycle updates through the CSR file's generic port, and arbitrates
//   that port for CSR instructions while no sequence is running.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid, ex_pc          commit instruction valid / PC
//   ex_ecall/mret/illegal    commit instruction event flags
//   irq_tint                 timer interrupt pending (already gated upstream)
//   csr_req*                 CSR instruction access (request / ready / rdata)
//   csr_id/re/we/wdata       CSR file port, csr_rdata combinational read data
//   stall                    hold the pipeline
//   redirect_valid/pc        one-cycle PC redirect strobe and target
module trap_sequencer #(
  parameter logic [63:0] ECALL_CAUSE = 64'd11,
  parameter logic [63:0] ILL_CAUSE   = 64'd2,
  parameter logic [63:0] TIMER_CAUSE = 64'h8000000000000007
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [63:0] ex_pc,
  input  logic        ex_ecall,
  input  logic        ex_mret,
  input  logic        ex_illegal,
  input  logic        irq_tint,
  input  logic        csr_req,
  input  logic [11:0] csr_req_id,
  input  logic        csr_req_we,
  input  logic [63:0] csr_req_wdata,
  output logic        csr_req_ready,
  output logic [63:0] csr_req_rdata,
  output logic [11:0] csr_id,
  output logic        csr_re,
  output logic        csr_we,
  output logic [63:0] csr_wdata,
  input  logic [63:0] csr_rdata,
  output logic        stall,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC, REDIR
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  state_t      state, state_nx;
  logic [63:0] epc_r, cause_r, tgt_r;
  logic        trap_ev, take;
  logic [63:0] rd_base, vec_off;

  assign trap_ev = irq_tint | ex_illegal | ex_ecall;
  assign take    = (state == IDLE) & ex_valid & (trap_ev | ex_mret);

  assign rd_base = {csr_rdata[63:2], 2'b00};
  assign vec_off = {56'd0, cause_r[5:0], 2'b00};

  // State register and latched sequence data
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      epc_r   <= '0;
      cause_r <= '0;
      tgt_r   <= '0;
    end else begin
      state <= state_nx;
      if (take && trap_ev) begin
        epc_r <= ex_pc;
        if (irq_tint)        cause_r <= TIMER_CAUSE;
        else if (ex_illegal) cause_r <= ILL_CAUSE;
        else                 cause_r <= ECALL_CAUSE;
      end
      // cause_r[63] marks an interrupt; only interrupts use vectored mode
      if (state == T_VEC) begin
        if (cause_r[63] && (csr_rdata[1:0] == 2'b01)) tgt_r <= rd_base + vec_off;
        else                                          tgt_r <= rd_base;
      end
      if (state == M_EPC) tgt_r <= rd_base;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take) state_nx = trap_ev ? T_EPC : M_STAT;
      T_EPC:   state_nx = T_CAUSE;
      T_CAUSE: state_nx = T_STAT;
      T_STAT:  state_nx = T_VEC;
      T_VEC:   state_nx = REDIR;
      M_STAT:  state_nx = M_EPC;
      M_EPC:   state_nx = REDIR;
      REDIR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: CSR port mux, stall and redirect
  always_comb begin
    csr_id         = '0;
    csr_re         = 1'b0;
    csr_we         = 1'b0;
    csr_wdata      = '0;
    csr_req_ready  = 1'b0;
    csr_req_rdata  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = (state != IDLE) && (state != REDIR);
    case (state)
      IDLE: begin
        stall = take;
        if (!take && csr_req) begin
          csr_req_ready = 1'b1;
          csr_id        = csr_req_id;
          csr_re        = 1'b1;
          csr_we        = csr_req_we;
          csr_wdata     = csr_req_wdata;
          csr_req_rdata = csr_rdata;
        end
      end
      T_EPC: begin
        csr_id    = CSR_MEPC;
        csr_we    = 1'b1;
        csr_wdata = epc_r;
      end
      T_CAUSE: begin
        csr_id    = CSR_MCAUSE;
        csr_we    = 1'b1;
        csr_wdata = cause_r;
      end
      T_STAT: begin
        // MPIE <= MIE, MIE <= 0, MPP <= M
        csr_id          = CSR_MSTATUS;
        csr_re          = 1'b1;
        csr_we          = 1'b1;
        csr_wdata       = csr_rdata;
        csr_wdata[7]    = csr_rdata[3];
        csr_wdata[3]    = 1'b0;
        csr_wdata[12:11] = 2'b11;
      end
      T_VEC: begin
        csr_id = CSR_MTVEC;
        csr_re = 1'b1;
      end
      M_STAT: begin
        // MIE <= MPIE, MPIE <= 1, MPP <= M
        csr_id          = CSR_MSTATUS;
        csr_re          = 1'b1;
        csr_we          = 1'b1;
        csr_wdata       = csr_rdata;
        csr_wdata[3]    = csr_rdata[7];
        csr_wdata[7]    = 1'b1;
        csr_wdata[12:11] = 2'b11;
      end
      M_EPC: begin
        csr_id = CSR_MEPC;
        csr_re = 1'b1;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt_r;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap/return sequencer and CSR-port arbiter for the single-cycle NPC core. It owns the CSR file's generic read/write port (`csr_id`/`csr_re`/`csr_we`/`csr_wdata`/`csr_rdata`) and shares it between CSR instructions and the trap machinery. Ecall, illegal-instruction, timer-interrupt and mret events are serialised into multi-cycle CSR update sequences, with the pipeline stalled until the redirect. The CSR file's dedicated `ecall`/`mret` inputs are tied low when this block is used.

## Interface
Parameters:
- `ECALL_CAUSE`, 64'd11: mcause value for ecall from M-mode.
- `ILL_CAUSE`, 64'd2: mcause value for illegal instruction.
- `TIMER_CAUSE`, 64'h8000000000000007: mcause value for the machine timer interrupt.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: instruction at commit is valid.
- `ex_pc` in 64: PC of the commit instruction.
- `ex_ecall`, `ex_mret`, `ex_illegal` in 1 each: event flags of the commit instruction.
- `irq_tint` in 1: timer interrupt pending, level, already gated by MIE/MTIE upstream in the CLINT.
- `csr_req` in 1: CSR instruction access request.
- `csr_req_id` in 12: CSR address of the request.
- `csr_req_we` in 1: request is a write.
- `csr_req_wdata` in 64: request write data.
- `csr_req_ready` out 1: request accepted this cycle.
- `csr_req_rdata` out 64: read data returned for the request.
- `csr_id` out 12, `csr_re` out 1, `csr_we` out 1, `csr_wdata` out 64: CSR file port.
- `csr_rdata` in 64: CSR file read data, combinational.
- `stall` out 1: hold the pipeline.
- `redirect_valid` out 1: one-cycle PC redirect strobe.
- `redirect_pc` out 64: redirect target.

## Operation
- **States:** IDLE, T_EPC, T_CAUSE, T_STAT, T_VEC, M_STAT, M_EPC, REDIR.
- **Take condition:** `take = ex_valid & (irq_tint | ex_illegal | ex_ecall | ex_mret)`, evaluated in IDLE only.
- **Event priority:** irq_tint > ex_illegal > ex_ecall > ex_mret > csr_req.
- **On take (trap):**
  - Latch `ex_pc` into `epc_r`.
  - Latch the cause into `cause_r`: TIMER, ILL or ECALL.
  - Next state T_EPC.
  - An interrupt is taken before the commit instruction executes; `epc_r` = that instruction's PC.
- **On take (mret):** next state M_STAT.
- **Trap sequence:**
  - T_EPC: `csr_id`=0x341, `we`=1, `wdata`=`epc_r`.
  - T_CAUSE: `csr_id`=0x342, `we`=1, `wdata`=`cause_r`.
  - T_STAT: `csr_id`=0x300, `re`=`we`=1 (read-modify-write in one cycle). `wdata` = `rdata` with bit7 (MPIE) = `rdata[3]`, bit3 (MIE) = 0, bits12:11 (MPP) = 2'b11.
  - T_VEC: `csr_id`=0x305, `re`=1. Latch `tgt_r`:
    - mode (`rdata[1:0]`) = 0, or any synchronous trap: `tgt_r = {rdata[63:2],2'b00}`.
    - mode = 1 and interrupt: `tgt_r = {rdata[63:2],2'b00} + (cause_r[5:0] << 2)`, 64-bit wrap.
  - Then REDIR.
- **mret sequence:**
  - M_STAT: `csr_id`=0x300, `re`=`we`=1. `wdata` = `rdata` with bit3 = `rdata[7]`, bit7 = 1, MPP = 2'b11.
  - M_EPC: `csr_id`=0x341, `re`=1. Latch `tgt_r = {rdata[63:2],2'b00}`. Then REDIR.
- **REDIR:** `redirect_valid`=1, `redirect_pc`=`tgt_r`, `stall`=0, next state IDLE.
- **CSR pass-through:** in IDLE with no take, `csr_req_ready`=`csr_req`. The port is driven from `csr_req_id`/`csr_req_we`/`csr_req_wdata` with `csr_re`=1. `csr_req_rdata`=`csr_rdata` in the same cycle; the CSR file commits the write at that edge.
- **Port idle:** when neither a sequence nor a pass-through drives the port, `csr_re`/`csr_we`=0, `csr_id`=0, `csr_wdata`=0.

## Timing
- **Reset:** state IDLE. `stall`, `redirect_valid`, `csr_req_ready`, `csr_re`, `csr_we`=0. `csr_id`, `csr_wdata`, `redirect_pc`, `csr_req_rdata`=0. `epc_r`, `cause_r`, `tgt_r` cleared.
- **Reset mid-sequence:** abort to IDLE next edge; no redirect is issued.
- **Stall:** `stall = (state ∉ {IDLE, REDIR}) | take`. It is combinational, so stall is high in the take cycle.
- **Trap latency:** take at cycle 0, writes at cycles 1–3, mtvec read at cycle 4, `redirect_valid` at cycle 5.
- **mret latency:** take at cycle 0, `redirect_valid` at cycle 3.
- **Simultaneous events:**
  - irq with ecall/illegal/mret: the interrupt wins; the instruction is not executed and is re-fetched after return.
  - Any take with `csr_req`: `csr_req_ready`=0 and the request is dropped (the instruction is flushed or retried).
- **Events outside IDLE:** events and `csr_req` arriving in a non-IDLE state are ignored; `csr_req_ready`=0 throughout.
- **irq held after trap:** `irq_tint` still high in REDIR or the next IDLE is taken again (upstream gating is responsible for deasserting once MIE=0).

## Test plan
- **Reset check:** reset, then idle 3 cycles → all outputs 0, state IDLE.
- **Ecall trap:** mtvec=0x80000100, ecall at `ex_pc`=0x80000040 → mepc=0x80000040, mcause=11, mstatus MIE 1→0 and MPIE=1; `redirect_valid` at cycle 5 with pc 0x80000100; `stall` high for cycles 0–4.
- **Vectored timer interrupt:** mtvec=0x80000101 (vectored), `irq_tint`+`ex_ecall` same cycle at pc 0x80000200 → mcause=0x8000000000000007, mepc=0x80000200, `redirect_pc`=0x8000011C.
- **mret:** mepc=0x80000044, mstatus MPIE=1, MIE=0 → MIE=1, MPIE=1, `redirect_pc`=0x80000044 at cycle 3.
- **CSR pass-through:** `csr_req` write mtvec=0x1234 in IDLE → ready same cycle; a following read returns 0x1234. The same request coinciding with `ex_illegal` → ready=0, mcause=2.
- **Reset mid-trap:** `rst` asserted in T_CAUSE → next cycle IDLE, no `redirect_valid`, `stall`=0.
